// File: rtl/ps2_pkg.sv
// Shared constants and state encoding for the PS/2 mouse host controller.
package ps2_pkg;

    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_ERR        = 8'hFC;
    localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_RATE   = 8'hF3;
    localparam logic [7:0] PS2_CMD_RES    = 8'hE8;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    localparam int TMR_W = 25;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_STREAM,
        ST_FAIL
    } state_e;

endpackage

// File: rtl/ps2_timeout.sv
// Loadable down-counter; expired is high once the loaded count has drained.
module ps2_timeout
    import ps2_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= limit;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/ps2mouse_ctrl.sv
// PS/2 mouse host: power-up command sequence with ACK/resend/retry handling,
// then 3-byte movement packet framing while streaming.
module ps2mouse_ctrl
    import ps2_pkg::*;
#(
    parameter int         TIMEOUT_CYC     = 65536,
    parameter int         BAT_TIMEOUT_CYC = 1 << 24,
    parameter int         MAX_RETRY       = 3,
    parameter logic [7:0] SAMPLE_RATE     = 8'h64,
    parameter logic [7:0] RESOLUTION      = 8'h02
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tx_req,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       ready,
    output logic       fail,
    output logic       pkt_valid,
    output logic [2:0] pkt_btn,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf
);

    localparam logic [TMR_W-1:0] TO_LD  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] BAT_LD = TMR_W'(BAT_TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [2:0]  retry_q, retry_d;
    logic [1:0]  resend_q, resend_d;
    logic        sent_q, sent_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  b0_q, b0_d;
    logic [7:0]  b1_q, b1_d;
    logic        tx_req_q, tx_req_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        pkt_valid_q, pkt_valid_d;
    logic [2:0]  pkt_btn_q, pkt_btn_d;
    logic [8:0]  pkt_dx_q, pkt_dx_d;
    logic [8:0]  pkt_dy_q, pkt_dy_d;
    logic [1:0]  pkt_ovf_q, pkt_ovf_d;
    logic        err, tmr_clr, tmr_load, expired;
    logic [7:0]  rom_byte;
    logic [TMR_W-1:0] tmr_limit;

    always_comb begin
        rom_byte = 8'h00;
        unique case (step_q)
            3'd0:    rom_byte = PS2_CMD_RESET;
            3'd1:    rom_byte = PS2_CMD_RATE;
            3'd2:    rom_byte = SAMPLE_RATE;
            3'd3:    rom_byte = PS2_CMD_RES;
            3'd4:    rom_byte = RESOLUTION;
            3'd5:    rom_byte = PS2_CMD_ENABLE;
            default: rom_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        resend_d    = resend_q;
        sent_d      = sent_q;
        cnt_d       = cnt_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        tx_req_d    = 1'b0;
        tx_data_d   = tx_data_q;
        pkt_valid_d = 1'b0;
        pkt_btn_d   = pkt_btn_q;
        pkt_dx_d    = pkt_dx_q;
        pkt_dy_d    = pkt_dy_q;
        pkt_ovf_d   = pkt_ovf_q;
        err         = 1'b0;
        tmr_clr     = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                step_d   = 3'd0;
                retry_d  = 3'd0;
                resend_d = 2'd0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (!sent_q) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = rom_byte;
                    sent_d    = 1'b1;
                end else if (tx_done) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    if (rx_data == PS2_ACK) begin
                        resend_d = 2'd0;
                        if (step_q == 3'd0) begin
                            state_d = ST_WAIT_BAT;
                        end else if (step_q == 3'd5) begin
                            cnt_d   = 2'd0;
                            state_d = ST_STREAM;
                        end else begin
                            step_d  = step_q + 3'd1;
                            state_d = ST_SEND;
                        end
                    end else if (rx_data == PS2_RESEND) begin
                        if (resend_q == 2'd2) begin
                            err = 1'b1;
                        end else begin
                            resend_d = resend_q + 2'd1;
                            state_d  = ST_SEND;
                        end
                    end else begin
                        err = 1'b1;
                    end
                end else if (expired) begin
                    err = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_valid) begin
                    if (rx_data == PS2_BAT_OK) begin
                        state_d = ST_WAIT_ID;
                    end else if (rx_data == PS2_ERR) begin
                        err = 1'b1;
                    end
                end else if (expired) begin
                    err = 1'b1;
                end
            end
            ST_WAIT_ID: begin
                if (rx_valid) begin
                    if (rx_data == 8'h00) begin
                        step_d   = 3'd1;
                        resend_d = 2'd0;
                        state_d  = ST_SEND;
                    end else begin
                        err = 1'b1;
                    end
                end else if (expired) begin
                    err = 1'b1;
                end
            end
            ST_STREAM: begin
                if (rx_valid) begin
                    unique case (cnt_q)
                        2'd0: begin
                            // Bit 3 is always set in a valid header byte.
                            if (rx_data[3]) begin
                                b0_d  = rx_data;
                                cnt_d = 2'd1;
                            end
                        end
                        2'd1: begin
                            if (b0_q == PS2_BAT_OK && rx_data == 8'h00) begin
                                cnt_d   = 2'd0;
                                state_d = ST_RESET;
                            end else begin
                                b1_d  = rx_data;
                                cnt_d = 2'd2;
                            end
                        end
                        2'd2: begin
                            pkt_valid_d = 1'b1;
                            pkt_btn_d   = b0_q[2:0];
                            pkt_ovf_d   = b0_q[7:6];
                            pkt_dx_d    = {b0_q[4], b1_q};
                            pkt_dy_d    = {b0_q[5], rx_data};
                            cnt_d       = 2'd0;
                        end
                        default: cnt_d = 2'd0;
                    endcase
                end else if (expired && cnt_q != 2'd0) begin
                    cnt_d   = 2'd0;
                    tmr_clr = 1'b1;
                end
            end
            ST_FAIL: ;
            default: state_d = ST_RESET;
        endcase

        if (err) begin
            step_d   = 3'd0;
            resend_d = 2'd0;
            if (int'(retry_q) >= MAX_RETRY) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + 3'd1;
                state_d = ST_SEND;
            end
        end

        if (state_d != ST_SEND) sent_d = 1'b0;
    end

    assign tmr_load  = (state_d != state_q) || rx_valid || tmr_clr;
    assign tmr_limit = (state_d == ST_WAIT_BAT) ? BAT_LD : TO_LD;

    ps2_timeout #(.W(TMR_W)) u_tmr (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .limit   (tmr_limit),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RESET;
            step_q      <= 3'd0;
            retry_q     <= 3'd0;
            resend_q    <= 2'd0;
            sent_q      <= 1'b0;
            cnt_q       <= 2'd0;
            b0_q        <= 8'h00;
            b1_q        <= 8'h00;
            tx_req_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            pkt_valid_q <= 1'b0;
            pkt_btn_q   <= 3'd0;
            pkt_dx_q    <= 9'd0;
            pkt_dy_q    <= 9'd0;
            pkt_ovf_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            resend_q    <= resend_d;
            sent_q      <= sent_d;
            cnt_q       <= cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            tx_req_q    <= tx_req_d;
            tx_data_q   <= tx_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_btn_q   <= pkt_btn_d;
            pkt_dx_q    <= pkt_dx_d;
            pkt_dy_q    <= pkt_dy_d;
            pkt_ovf_q   <= pkt_ovf_d;
        end
    end

    assign tx_req    = tx_req_q;
    assign tx_data   = tx_data_q;
    assign ready     = (state_q == ST_STREAM);
    assign fail      = (state_q == ST_FAIL);
    assign pkt_valid = pkt_valid_q;
    assign pkt_btn   = pkt_btn_q;
    assign pkt_dx    = pkt_dx_q;
    assign pkt_dy    = pkt_dy_q;
    assign pkt_ovf   = pkt_ovf_q;

endmodule

// File: tb/tb_ps2mouse_ctrl.sv
// Directed bench for ps2mouse_ctrl: init, resend, no-device, packets, hot-plug.
module tb_ps2mouse_ctrl;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       ready;
    logic       fail;
    logic       pkt_valid;
    logic [2:0] pkt_btn;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic [1:0] pkt_ovf;

    int checks   = 0;
    int failures = 0;
    int pkts     = 0;
    int gap      = 0;
    int txcnt    = 0;

    ps2mouse_ctrl #(
        .TIMEOUT_CYC     (TO),
        .BAT_TIMEOUT_CYC (200),
        .MAX_RETRY       (3),
        .SAMPLE_RATE     (8'h64),
        .RESOLUTION      (8'h02)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .ready     (ready),
        .fail      (fail),
        .pkt_valid (pkt_valid),
        .pkt_btn   (pkt_btn),
        .pkt_dx    (pkt_dx),
        .pkt_dy    (pkt_dy),
        .pkt_ovf   (pkt_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pkt_valid === 1'b1) pkts++;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx();
        gap = 0;
        while (tx_req !== 1'b1 && gap < 1000) begin
            @(negedge clk);
            gap++;
        end
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        wait_tx();
        chk({tag, "_req"}, 16'(tx_req), 16'd1);
        chk({tag, "_data"}, 16'(tx_data), 16'(b));
        @(negedge clk);
        chk({tag, "_pulse"}, 16'(tx_req), 16'd0);
        tick(2);
        tx_done = 1'b1;
        chk({tag, "_hold"}, 16'(tx_data), 16'(b));
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic ack_step(input string tag, input logic [7:0] b);
        expect_tx(tag, b);
        send_rx(8'hFA);
    endtask

    task automatic finish_init();
        ack_step("f3", 8'hF3);
        ack_step("rate", 8'h64);
        ack_step("e8", 8'hE8);
        ack_step("res", 8'h02);
        ack_step("f4", 8'hF4);
    endtask

    task automatic reset_init();
        ack_step("ff", 8'hFF);
        send_rx(8'hAA);
        send_rx(8'h00);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_txreq"}, 16'(tx_req), 16'd0);
        chk({tag, "_txdata"}, 16'(tx_data), 16'h00);
        chk({tag, "_ready"}, 16'(ready), 16'd0);
        chk({tag, "_fail"}, 16'(fail), 16'd0);
        chk({tag, "_pv"}, 16'(pkt_valid), 16'd0);
        chk({tag, "_btn"}, 16'(pkt_btn), 16'd0);
        chk({tag, "_dx"}, 16'(pkt_dx), 16'd0);
        chk({tag, "_dy"}, 16'(pkt_dy), 16'd0);
        chk({tag, "_ovf"}, 16'(pkt_ovf), 16'd0);
    endtask

    initial begin
        reset    = 1'b1;
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(2);
        chk_reset_outs("rst");
        reset = 1'b0;

        // clean init
        reset_init();
        finish_init();
        chk("init_ready", 16'(ready), 16'd1);
        chk("init_fail", 16'(fail), 16'd0);

        // basic packet: 29 05 FB
        send_rx(8'h29);
        send_rx(8'h05);
        send_rx(8'hFB);
        chk("p1_valid", 16'(pkt_valid), 16'd1);
        chk("p1_btn", 16'(pkt_btn), 16'd1);
        chk("p1_dx", 16'(pkt_dx), 16'h005);
        chk("p1_dy", 16'(pkt_dy), 16'h1FB);
        chk("p1_ovf", 16'(pkt_ovf), 16'd0);
        tick(1);
        chk("p1_pulse", 16'(pkt_valid), 16'd0);
        chk("p1_hold", 16'(pkt_dy), 16'h1FB);
        chk("p1_count", 16'(pkts), 16'd1);

        // resync and inter-byte gap
        send_rx(8'h05);
        send_rx(8'h08);
        send_rx(8'h01);
        tick(TO + 16);
        send_rx(8'h08);
        send_rx(8'h02);
        send_rx(8'h03);
        chk("p2_valid", 16'(pkt_valid), 16'd1);
        chk("p2_btn", 16'(pkt_btn), 16'd0);
        chk("p2_dx", 16'(pkt_dx), 16'h002);
        chk("p2_dy", 16'(pkt_dy), 16'h003);
        tick(2);
        chk("p2_count", 16'(pkts), 16'd2);

        // overflow bits and sign on X
        send_rx(8'hD8);
        send_rx(8'h10);
        send_rx(8'h20);
        chk("p3_ovf", 16'(pkt_ovf), 16'd3);
        chk("p3_dx", 16'(pkt_dx), 16'h110);
        chk("p3_dy", 16'(pkt_dy), 16'h020);
        tick(2);

        // hot-plug AA 00 in stream
        send_rx(8'hAA);
        chk("hp_ready_hold", 16'(ready), 16'd1);
        send_rx(8'h00);
        chk("hp_ready_drop", 16'(ready), 16'd0);
        chk("hp_count", 16'(pkts), 16'd3);
        wait_tx();
        chk("hp_ff_req", 16'(tx_req), 16'd1);
        chk("hp_ff_data", 16'(tx_data), 16'hFF);
        tick(1);
        reset = 1'b1;
        #1;
        chk_reset_outs("midsend");
        tick(2);
        reset = 1'b0;

        // resend handling
        reset_init();
        expect_tx("rs_f3a", 8'hF3);
        send_rx(8'hFE);
        expect_tx("rs_f3b", 8'hF3);
        send_rx(8'hFA);
        expect_tx("rs_64a", 8'h64);
        send_rx(8'hFE);
        expect_tx("rs_64b", 8'h64);
        send_rx(8'hFE);
        expect_tx("rs_64c", 8'h64);
        send_rx(8'hFE);
        expect_tx("rs_restart", 8'hFF);
        chk("rs_fail", 16'(fail), 16'd0);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        finish_init();
        chk("rs_ready", 16'(ready), 16'd1);

        // no device: four FF attempts then sticky fail
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        expect_tx("nd_ff0", 8'hFF);
        for (int i = 1; i < 4; i++) begin
            expect_tx("nd_ff", 8'hFF);
            chk("nd_gap", 16'(gap), 16'(TO + 1));
        end
        tick(TO + 6);
        chk("nd_fail", 16'(fail), 16'd1);
        chk("nd_ready", 16'(ready), 16'd0);
        txcnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_req === 1'b1) txcnt++;
        end
        chk("nd_no_tx", 16'(txcnt), 16'd0);
        chk("nd_sticky", 16'(fail), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
